// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber / error aggregator for the ECC register array.
// Define ECC_SCRUB_WRITEBACK_EN to build the corrective write-back path; otherwise monitor-only.
module ecc_scrub_ctrl #(
    parameter int NUM_REGS       = 100,
    parameter int NUM_REG_BITS   = 8,
    parameter int SCRUB_INTERVAL = 4,
    parameter int CNT_W          = 16,
    parameter int SBE_THRESH     = 8,
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                             clk,
    input  logic                             reset_b,
    input  logic                             scrub_en,
    input  logic [NUM_REGS*NUM_REG_BITS-1:0] reg_dout_flat,
    input  logic [NUM_REGS-1:0]              single_bit_err,
    input  logic [NUM_REGS-1:0]              double_bit_err,
    input  logic [NUM_REGS-1:0]              parity_bit_err,
    input  logic [NUM_REGS-1:0]              host_w_en,
    output logic [NUM_REGS-1:0]              scrub_w_en,
    output logic [NUM_REG_BITS-1:0]          scrub_w_din,
    output logic [CNT_W-1:0]                 sbe_count,
    output logic [CNT_W-1:0]                 dbe_count,
    input  logic                             cnt_clr,
    output logic                             err_irq,
    input  logic                             irq_clr,
    output logic [IDX_W-1:0]                 dbe_first_idx,
    output logic                             dbe_first_valid,
    output logic                             busy,
    output logic                             pass_done
);
    // state  | meaning
    // IDLE   | not scanning, idx held at 0
    // CHECK  | sample error flags of register idx
    // WRITE  | scrub write of corrected data (write-back build only)
    // SETTLE | let register output update after write (write-back build only)
    // WAIT   | SCRUB_INTERVAL idle cycles, then advance idx
    localparam int TMR_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
`ifdef ECC_SCRUB_WRITEBACK_EN
        WRITE,
        SETTLE,
`endif
        WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             sbe_inc, dbe_det, pass_d, reg_done, adv;
    logic             sbe_hit;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmr_d    = tmr_q;
        sbe_inc  = 1'b0;
        dbe_det  = 1'b0;
        pass_d   = 1'b0;
        reg_done = 1'b0;
        adv      = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (scrub_en) state_d = CHECK;
            end
            CHECK: begin
                if (double_bit_err[idx_q]) begin
                    dbe_det  = 1'b1;
                    reg_done = 1'b1;
                end else if (single_bit_err[idx_q] || parity_bit_err[idx_q]) begin
`ifdef ECC_SCRUB_WRITEBACK_EN
                    state_d = WRITE;
`else
                    sbe_inc  = 1'b1;
                    reg_done = 1'b1;
`endif
                end else begin
                    reg_done = 1'b1;
                end
            end
`ifdef ECC_SCRUB_WRITEBACK_EN
            WRITE: begin
                sbe_inc = !host_w_en[idx_q];
                state_d = SETTLE;
            end
            SETTLE: reg_done = 1'b1;
`endif
            WAIT: begin
                if (tmr_q == '0) adv = 1'b1;
                else             tmr_d = tmr_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // A zero interval skips WAIT entirely so the next CHECK follows directly.
        if (reg_done) begin
            if (SCRUB_INTERVAL == 0) begin
                adv = 1'b1;
            end else begin
                state_d = WAIT;
                tmr_d   = TMR_W'(SCRUB_INTERVAL - 1);
            end
        end

        if (adv) begin
            if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                idx_d  = '0;
                pass_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
            state_d = scrub_en ? CHECK : IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            tmr_q     <= '0;
            busy      <= 1'b0;
            pass_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmr_q     <= tmr_d;
            busy      <= (state_d != IDLE);
            pass_done <= pass_d;
        end
    end

`ifdef ECC_SCRUB_WRITEBACK_EN
    logic [NUM_REGS-1:0] wen_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wen_q       <= '0;
            scrub_w_din <= '0;
        end else begin
            wen_q <= (state_d == WRITE) ? (NUM_REGS'(1) << idx_q) : '0;
            if (state_q == CHECK && state_d == WRITE)
                scrub_w_din <= reg_dout_flat[int'(idx_q)*NUM_REG_BITS +: NUM_REG_BITS];
        end
    end

    // Host write in the same cycle wins; masking here avoids a collision on the shared port.
    assign scrub_w_en = wen_q & ~host_w_en;
`else
    logic unused_wb_inputs;
    assign unused_wb_inputs = ^{host_w_en, reg_dout_flat};
    assign scrub_w_en  = '0;
    assign scrub_w_din = '0;
`endif

    assign sbe_hit = sbe_inc && !cnt_clr && (sbe_count != '1) &&
                     ((sbe_count + 1'b1) == CNT_W'(SBE_THRESH));

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sbe_count       <= '0;
            dbe_count       <= '0;
            err_irq         <= 1'b0;
            dbe_first_idx   <= '0;
            dbe_first_valid <= 1'b0;
        end else begin
            if (cnt_clr)                           sbe_count <= '0;
            else if (sbe_inc && sbe_count != '1)   sbe_count <= sbe_count + 1'b1;

            if (cnt_clr)                           dbe_count <= '0;
            else if (dbe_det && dbe_count != '1)   dbe_count <= dbe_count + 1'b1;

            if (dbe_det || sbe_hit) err_irq <= 1'b1;
            else if (irq_clr)       err_irq <= 1'b0;

            // A dbe coinciding with irq_clr becomes the new first failure.
            if (dbe_det && (!dbe_first_valid || irq_clr)) begin
                dbe_first_idx   <= idx_q;
                dbe_first_valid <= 1'b1;
            end else if (irq_clr) begin
                dbe_first_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Self-checking bench for ecc_scrub_ctrl: table-driven single-pass scenarios plus
// hand-written sequences for pass timing, counter saturation and async reset mid-write.
module tb_ecc_scrub_ctrl;
    localparam int NR = 4;
    localparam int NB = 8;
    localparam int CW = 2;
`ifdef ECC_SCRUB_WRITEBACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    logic scrub_en = 1'b0, cnt_clr = 1'b0, irq_clr = 1'b0;
    logic [NR*NB-1:0] dout;
    logic [NR-1:0] sbe_f = '0, dbe_f = '0, par_f = '0, host = '0;

    logic [NR-1:0] wen;
    logic [NB-1:0] din;
    logic [CW-1:0] sbe_c, dbe_c;
    logic          irq, fval, busy, pass;
    logic [1:0]    fidx;

    logic [NR-1:0] wen2;
    logic [NB-1:0] din2;
    logic [15:0]   sbe_c2, dbe_c2;
    logic          irq2, fval2, busy2, pass2;
    logic [1:0]    fidx2;

    ecc_scrub_ctrl #(.NUM_REGS(NR), .NUM_REG_BITS(NB), .SCRUB_INTERVAL(0),
                     .CNT_W(CW), .SBE_THRESH(2)) u_dut (
        .clk(clk), .reset_b(reset_b), .scrub_en(scrub_en), .reg_dout_flat(dout),
        .single_bit_err(sbe_f), .double_bit_err(dbe_f), .parity_bit_err(par_f),
        .host_w_en(host), .scrub_w_en(wen), .scrub_w_din(din), .sbe_count(sbe_c),
        .dbe_count(dbe_c), .cnt_clr(cnt_clr), .err_irq(irq), .irq_clr(irq_clr),
        .dbe_first_idx(fidx), .dbe_first_valid(fval), .busy(busy), .pass_done(pass));

    ecc_scrub_ctrl #(.NUM_REGS(NR), .NUM_REG_BITS(NB), .SCRUB_INTERVAL(2),
                     .CNT_W(16), .SBE_THRESH(2)) u_dut2 (
        .clk(clk), .reset_b(reset_b), .scrub_en(scrub_en), .reg_dout_flat(dout),
        .single_bit_err(sbe_f), .double_bit_err(dbe_f), .parity_bit_err(par_f),
        .host_w_en(host), .scrub_w_en(wen2), .scrub_w_din(din2), .sbe_count(sbe_c2),
        .dbe_count(dbe_c2), .cnt_clr(cnt_clr), .err_irq(irq2), .irq_clr(irq_clr),
        .dbe_first_idx(fidx2), .dbe_first_valid(fval2), .busy(busy2), .pass_done(pass2));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || busy2) && n < 60) begin
            step();
            n++;
        end
        chk("idle_reached", {30'd0, busy, busy2}, 32'd0);
    endtask

    task automatic clear_all();
        wait_idle();
        cnt_clr = 1'b1;
        irq_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        irq_clr = 1'b0;
        chk("clr_sbe", sbe_c, 0);
        chk("clr_dbe", dbe_c, 0);
        chk("clr_irq", irq, 0);
        chk("clr_fval", fval, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wen"}, wen, 0);
        chk({tag, "_din"}, din, 0);
        chk({tag, "_sbe"}, sbe_c, 0);
        chk({tag, "_dbe"}, dbe_c, 0);
        chk({tag, "_irq"}, irq, 0);
        chk({tag, "_fidx"}, fidx, 0);
        chk({tag, "_fval"}, fval, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pass"}, pass, 0);
    endtask

    typedef struct {
        string      name;
        logic [3:0] s, d, p, h;
        int         e_sbe, e_dbe, e_irq, e_fval, e_fidx, e_cyc, e_wen, e_din;
    } vec_t;

    vec_t tv[8];

    initial begin
        int cyc, p1a, p1b, p2a, p2b;
        logic [NR-1:0] wen_or;
        logic [NB-1:0] last_din;
        bit done;

        dout = {8'hC3, 8'hA5, 8'h5A, 8'h3C};

        tv[0] = '{"clean",     4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 5, 0, 0};
        tv[1] = '{"sbe2",      4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0,
                  WB ? 7 : 5, WB ? 4 : 0, WB ? 8'hA5 : 0};
        tv[2] = '{"sbe2_host", 4'b0100, 4'b0000, 4'b0000, 4'b0100, WB ? 0 : 1, 0, 0, 0, 0,
                  WB ? 7 : 5, 0, 0};
        tv[3] = '{"dbe_sbe1",  4'b0010, 4'b0010, 4'b0000, 4'b0000, 0, 1, 1, 1, 1, 5, 0, 0};
        tv[4] = '{"dbe1_dbe3", 4'b0000, 4'b1010, 4'b0000, 4'b0000, 0, 2, 1, 1, 1, 5, 0, 0};
        tv[5] = '{"sbe0_par3", 4'b0001, 4'b0000, 4'b1000, 4'b0000, 2, 0, 1, 0, 0,
                  WB ? 9 : 5, WB ? 9 : 0, WB ? 8'hC3 : 0};
        tv[6] = '{"par1",      4'b0000, 4'b0000, 4'b0010, 4'b0000, 1, 0, 0, 0, 0,
                  WB ? 7 : 5, WB ? 2 : 0, WB ? 8'h5A : 0};
        tv[7] = '{"dbe_all",   4'b1111, 4'b1111, 4'b0000, 4'b0000, 0, 3, 1, 1, 0, 5, 0, 0};

        #3;
        chk_reset_vals("rst");
        @(negedge clk);
        reset_b = 1'b1;
        step();
        chk_reset_vals("post_rst");

        // One full pass per table entry, checked at the pass_done pulse.
        for (int i = 0; i < 8; i++) begin
            clear_all();
            sbe_f = tv[i].s; dbe_f = tv[i].d; par_f = tv[i].p; host = tv[i].h;
            scrub_en = 1'b1;
            cyc = 0; wen_or = '0; last_din = '0; done = 1'b0;
            while (!done && cyc < 40) begin
                step();
                cyc++;
                if (wen != '0) begin
                    wen_or   = wen_or | wen;
                    last_din = din;
                end
                if (pass) done = 1'b1;
            end
            scrub_en = 1'b0;
            chk({tv[i].name, "_cyc"},  cyc, tv[i].e_cyc);
            chk({tv[i].name, "_sbe"},  sbe_c, tv[i].e_sbe);
            chk({tv[i].name, "_dbe"},  dbe_c, tv[i].e_dbe);
            chk({tv[i].name, "_irq"},  irq, tv[i].e_irq);
            chk({tv[i].name, "_fval"}, fval, tv[i].e_fval);
            if (tv[i].e_fval != 0) chk({tv[i].name, "_fidx"}, fidx, tv[i].e_fidx);
            chk({tv[i].name, "_wen"},  wen_or, tv[i].e_wen);
            chk({tv[i].name, "_din"},  last_din, tv[i].e_din);
        end

        // Pass period: interval 0 -> every 4 cycles, interval 2 -> every 12 cycles.
        clear_all();
        sbe_f = '0; dbe_f = '0; par_f = '0; host = '0;
        scrub_en = 1'b1;
        p1a = 0; p1b = 0; p2a = 0; p2b = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (pass)  begin if (p1a == 0) p1a = c; else if (p1b == 0) p1b = c; end
            if (pass2) begin if (p2a == 0) p2a = c; else if (p2b == 0) p2b = c; end
            chk("clean_wen", wen, 0);
        end
        scrub_en = 1'b0;
        chk("pass1_first", p1a, 5);
        chk("pass1_period", p1b - p1a, 4);
        chk("pass2_first", p2a, 13);
        chk("pass2_period", p2b - p2a, 12);
        chk("clean_cnt", {sbe_c, dbe_c}, 0);

        // Six dbe events on a 2-bit counter hold at 3; first index stays 0.
        clear_all();
        dbe_f = 4'b1111;
        scrub_en = 1'b1;
        cyc = 0;
        while (!pass && cyc < 40) begin
            step();
            cyc++;
        end
        step();
        step();
        scrub_en = 1'b0;
        chk("sat_dbe", dbe_c, 3);
        chk("sat_fidx", fidx, 0);
        chk("sat_irq", irq, 1);
        chk("sat_dbe2_wide", dbe_c2 != 0, 1);

        // Asynchronous reset while the scrub write is in flight.
        clear_all();
        dbe_f = 4'b0001; sbe_f = 4'b0100;
        scrub_en = 1'b1;
        cyc = 0;
        while (wen == '0 && sbe_c == '0 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("mid_write_reached", (wen != '0) || (sbe_c != '0), 1);
        chk("mid_write_irq", irq, 1);
        #2;
        reset_b = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        scrub_en = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
        step();
        chk_reset_vals("after_async_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
